// File: rtl/fp16_div_seq.sv
// Iterative binary16 divider: radix-2 restoring division, one quotient bit per clock.
// Subnormal operands and results are flushed to signed zero.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   DIV   | one quotient bit per clock, 13 iterations
//   ROUND | normalise, round, classify overflow/underflow
//   DONE  | result held until out_ready
module fp16_div_seq #(
  parameter int          QBITS     = 13,
  parameter logic [15:0] NAN_CANON = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(QBITS - 1);

  state_t             state, state_nxt;
  logic [11:0]        rem;
  logic [10:0]        den;
  logic [QBITS-1:0]   quo;
  logic [3:0]         cnt;
  logic               sign;
  logic [1:0]         rmode;
  logic signed [6:0]  exp_q;

  // operand classification at accept
  logic [4:0]         x_exp, y_exp;
  logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic               special, in_sign;
  logic [15:0]        spec_res;
  logic [4:0]         spec_flags;
  logic signed [6:0]  exp_acc;

  always_comb begin
    x_exp      = x[14:10];
    y_exp      = y[14:10];
    x_zero     = (x_exp == 5'd0);
    y_zero     = (y_exp == 5'd0);
    x_inf      = (x_exp == 5'h1F) && (x[9:0] == 10'd0);
    y_inf      = (y_exp == 5'h1F) && (y[9:0] == 10'd0);
    x_nan      = (x_exp == 5'h1F) && (x[9:0] != 10'd0);
    y_nan      = (y_exp == 5'h1F) && (y[9:0] != 10'd0);
    special    = x_zero || y_zero || (x_exp == 5'h1F) || (y_exp == 5'h1F);
    in_sign    = x[15] ^ y[15];
    exp_acc    = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp}) + 7'sd14;
    spec_res   = {in_sign, 15'h0000};
    spec_flags = 5'b00000;
    if (x_nan || y_nan) begin
      spec_res   = NAN_CANON;
      spec_flags = {(x_nan && !x[9]) || (y_nan && !y[9]), 4'b0000};
    end else if ((x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_res   = NAN_CANON;
      spec_flags = 5'b10000;
    end else if (x_inf) begin
      spec_res   = {in_sign, 15'h7C00};
    end else if (y_zero) begin
      spec_res   = {in_sign, 15'h7C00};
      spec_flags = 5'b01000;
    end
  end

  // one restoring step
  logic        ge;
  logic [11:0] rem_sub, rem_nxt;

  always_comb begin
    ge      = (rem >= {1'b0, den});
    rem_sub = ge ? (rem - {1'b0, den}) : rem;
    rem_nxt = rem_sub << 1;
  end

  // normalise and round
  logic              norm, g, st, lsb, inc, carry, ovf_inf;
  logic [9:0]        frac_src;
  logic [10:0]       frac_sum;
  logic signed [6:0] e_pre, e_fin;
  logic [15:0]       rnd_res;
  logic [4:0]        rnd_flags;

  always_comb begin
    norm     = quo[QBITS-1];
    frac_src = norm ? quo[QBITS-2 -: 10] : quo[QBITS-3 -: 10];
    g        = norm ? quo[QBITS-12] : quo[QBITS-13];
    st       = norm ? (quo[0] || (rem != 12'd0)) : (rem != 12'd0);
    lsb      = frac_src[0];
    e_pre    = exp_q + (norm ? 7'sd1 : 7'sd0);
    case (rmode)
      2'b01:   inc = g && (st || lsb);
      2'b10:   inc = !sign && (g || st);
      2'b11:   inc = sign && (g || st);
      default: inc = 1'b0;
    endcase
    frac_sum = {1'b0, frac_src} + {10'd0, inc};
    carry    = frac_sum[10];
    e_fin    = e_pre + (carry ? 7'sd1 : 7'sd0);
    ovf_inf  = (rmode == 2'b01) || ((rmode == 2'b10) && !sign) || ((rmode == 2'b11) && sign);
    if (e_fin >= 7'sd31) begin
      rnd_res   = ovf_inf ? {sign, 15'h7C00} : {sign, 15'h7BFF};
      rnd_flags = 5'b00101;
    end else if (e_fin <= 7'sd0) begin
      rnd_res   = {sign, 15'h0000};
      rnd_flags = 5'b00011;
    end else begin
      rnd_res   = {sign, e_fin[4:0], frac_sum[9:0]};
      rnd_flags = {4'b0000, g || st};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : DIV;
      DIV:     if (cnt == 4'd0) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 16'h0000;
      flags  <= 5'b00000;
      rem    <= 12'd0;
      den    <= 11'd0;
      quo    <= '0;
      cnt    <= 4'd0;
      sign   <= 1'b0;
      rmode  <= 2'b00;
      exp_q  <= 7'sd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= in_sign;
          rmode <= roundmode;
          flags <= 5'b00000;
          if (special) begin
            result <= spec_res;
            flags  <= spec_flags;
          end else begin
            rem   <= {2'b01, x[9:0]};
            den   <= {1'b1, y[9:0]};
            quo   <= '0;
            cnt   <= CNT_INIT;
            exp_q <= exp_acc;
          end
        end
        DIV: begin
          quo <= {quo[QBITS-2:0], ge};
          rem <= rem_nxt;
          cnt <= cnt - 4'd1;
        end
        ROUND: begin
          result <= rnd_res;
          flags  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: directed vector table, random operands against an
// integer-arithmetic reference model, and handshake/reset sequences.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, result;
  logic [1:0]  roundmode;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_div_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .roundmode(roundmode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  rm;
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Quotient from exact integer division of the significands, then IEEE-style rounding.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                                output logic [15:0] r, output logic [4:0] f);
    int     ae, be, e;
    longint mx, my, sig, scale, rest;
    bit     s, an, bn, az, bz, ai, bi, g, st, inc;
    s  = a[15] ^ b[15];
    ae = int'(a[14:10]);
    be = int'(b[14:10]);
    an = (ae == 31) && (a[9:0] != 0);
    bn = (be == 31) && (b[9:0] != 0);
    ai = (ae == 31) && (a[9:0] == 0);
    bi = (be == 31) && (b[9:0] == 0);
    az = (ae == 0);
    bz = (be == 0);
    r = 16'h0000;
    f = 5'b00000;
    if (an || bn) begin
      r = 16'h7E00;
      f[4] = (an && !a[9]) || (bn && !b[9]);
    end else if ((az && bz) || (ai && bi)) begin
      r = 16'h7E00; f = 5'b10000;
    end else if (ai) begin
      r = {s, 15'h7C00};
    end else if (bz) begin
      r = {s, 15'h7C00}; f = 5'b01000;
    end else if (az || bi) begin
      r = {s, 15'h0000};
    end else begin
      mx = 1024 + longint'(a[9:0]);
      my = 1024 + longint'(b[9:0]);
      if (mx >= my) begin e = ae - be + 15; scale = 1024; end
      else          begin e = ae - be + 14; scale = 2048; end
      sig  = (mx * scale) / my;
      rest = mx * scale * 2;
      g    = ((rest / my) % 2) == 1;
      st   = (rest % my) != 0;
      case (rm)
        2'b01:   inc = g && (st || (sig % 2 == 1));
        2'b10:   inc = !s && (g || st);
        2'b11:   inc = s && (g || st);
        default: inc = 1'b0;
      endcase
      sig = sig + (inc ? 1 : 0);
      if (sig == 2048) begin sig = 1024; e = e + 1; end
      if (e >= 31) begin
        f = 5'b00101;
        if (rm == 2'b01 || (rm == 2'b10 && !s) || (rm == 2'b11 && s)) r = {s, 15'h7C00};
        else r = {s, 15'h7BFF};
      end else if (e <= 0) begin
        r = {s, 15'h0000}; f = 5'b00011;
      end else begin
        r = {s, e[4:0], sig[9:0]};
        f = {4'b0000, g || st};
      end
    end
  endfunction

  function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) || (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
    @(negedge clk);
    check("start_in_ready", in_ready, 1);
    x = a; y = b; roundmode = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    x         = 16'($urandom);
    y         = 16'($urandom);
    roundmode = 2'($urandom);
  endtask

  // edges after the accepting edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, er;
    logic [4:0]  f, ef;
    logic [15:0] a, b;
    logic [1:0]  rm;
    int          lat;

    tbl.push_back('{16'h3C00, 16'h3C00, 2'b01, 16'h3C00, 5'h00, 14});
    tbl.push_back('{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'h01, 14});
    tbl.push_back('{16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'h01, 14});
    tbl.push_back('{16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'h01, 14});
    tbl.push_back('{16'h3C00, 16'h4200, 2'b11, 16'h3555, 5'h01, 14});
    tbl.push_back('{16'hBC00, 16'h4200, 2'b11, 16'hB556, 5'h01, 14});
    tbl.push_back('{16'h4200, 16'h3C00, 2'b01, 16'h4200, 5'h00, 14});
    tbl.push_back('{16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'h08, 0});
    tbl.push_back('{16'hBC00, 16'h0000, 2'b01, 16'hFC00, 5'h08, 0});
    tbl.push_back('{16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'h10, 0});
    tbl.push_back('{16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'h10, 0});
    tbl.push_back('{16'h7E00, 16'h3C00, 2'b01, 16'h7E00, 5'h00, 0});
    tbl.push_back('{16'h3C00, 16'h7D00, 2'b01, 16'h7E00, 5'h10, 0});
    tbl.push_back('{16'h7C00, 16'hFC00, 2'b01, 16'h7E00, 5'h10, 0});
    tbl.push_back('{16'h7C00, 16'hBC00, 2'b01, 16'hFC00, 5'h00, 0});
    tbl.push_back('{16'h3C00, 16'h7C00, 2'b01, 16'h0000, 5'h00, 0});
    tbl.push_back('{16'h8000, 16'h3C00, 2'b01, 16'h8000, 5'h00, 0});
    tbl.push_back('{16'h0200, 16'h3C00, 2'b01, 16'h0000, 5'h00, 0});
    tbl.push_back('{16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'h05, 14});
    tbl.push_back('{16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'h05, 14});
    tbl.push_back('{16'h7BFF, 16'h1400, 2'b11, 16'h7BFF, 5'h05, 14});
    tbl.push_back('{16'hFBFF, 16'h1400, 2'b11, 16'hFC00, 5'h05, 14});
    tbl.push_back('{16'h0400, 16'h7800, 2'b01, 16'h0000, 5'h03, 14});
    tbl.push_back('{16'h8400, 16'h7800, 2'b01, 16'h8000, 5'h03, 14});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = 16'h0000; y = 16'h0000; roundmode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; x = 16'h3C00; y = 16'h0000;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 16'h0000);
    check("reset_flags", flags, 5'b00000);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;

    foreach (tbl[i]) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].rm);
      wait_valid(lat);
      check($sformatf("vec%0d_result", i), result, tbl[i].res);
      check($sformatf("vec%0d_flags", i), flags, tbl[i].fl);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      release_out();
    end

    for (int i = 0; i < 150; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      rm = 2'($urandom);
      model(a, b, rm, er, ef);
      start_op(a, b, rm);
      wait_valid(lat);
      r = result;
      f = flags;
      check($sformatf("rnd%0d_result x=%h y=%h rm=%0d", i, a, b, rm), r, er);
      check($sformatf("rnd%0d_flags", i), f, ef);
      check($sformatf("rnd%0d_latency", i), lat, is_special(a, b) ? 0 : 14);
      release_out();
    end

    // output hold under backpressure, then no accept in DONE
    start_op(16'h3C00, 16'h4200, 2'b01);
    wait_valid(lat);
    check("hold_latency", lat, 14);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 16'h3555);
      check("hold_flags", flags, 5'h01);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b1; x = 16'h3C00; y = 16'h0000; roundmode = 2'b01; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("done_no_accept_out_valid", out_valid, 0);
    check("done_no_accept_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accept_out_valid", out_valid, 1);
    check("next_accept_result", result, 16'h7C00);
    check("next_accept_flags", flags, 5'h08);
    release_out();

    // reset in the middle of the iteration
    start_op(16'h3C00, 16'h4200, 2'b01);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_result", result, 16'h0000);
    check("midreset_flags", flags, 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    start_op(16'h4000, 16'h4000, 2'b01);
    wait_valid(lat);
    check("post_reset_result", result, 16'h3C00);
    check("post_reset_flags", flags, 5'b00000);
    check("post_reset_latency", lat, 14);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
